// File: rtl/adc_circ_buffer_pkg.sv
// Shared types and helpers for the ADC circular capture buffer.
// Used by adc_circ_buffer and circ_ram.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    READOUT
  } state_t;

  // Buffer pointers are exactly ADDR_W bits wide, so plain addition wraps modulo DEPTH.
  function automatic logic [ADC_ADDR_W-1:0] ptr_add(input logic [ADC_ADDR_W-1:0] ptr,
                                                    input logic [ADC_ADDR_W-1:0] n);
    return ptr + n;
  endfunction

endpackage

// File: rtl/adc_circ_buffer_circ_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Written so that it maps onto a single block RAM.
module circ_ram
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = ADC_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/adc_circ_buffer.sv
// Pre/post-trigger capture into a circular sample buffer with valid/ready readout.
// Optional self-trigger on a sample threshold: define ADC_CIRC_BUFFER_SELF_TRIG_EN.
module adc_circ_buffer
  import adc_pkg::*;
#(
  parameter int DATA_W    = ADC_DATA_W,
  parameter int ADDR_W    = ADC_ADDR_W,
  parameter int POST_TRIG = 192
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
  ,
  parameter logic [DATA_W-1:0] THRESH = 12'd2048
`endif
) (
  input  logic              FASTCLK,
  input  logic              RESET_n,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_WE,
  input  logic              ARM,
  input  logic              TRIG,
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
  input  logic              TRIG_SRC,
`endif
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              RD_LAST,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              TRIG_LOST
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PRE   = DEPTH - POST_TRIG;
  localparam logic [ADDR_W:0] PRE_C  = (ADDR_W + 1)'(PRE);
  localparam logic [ADDR_W:0] POST_C = (ADDR_W + 1)'(POST_TRIG);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              trig_lost_q, trig_lost_d;
  logic              rd_valid_q, rd_valid_d;

  logic              ext_trig;
  logic              trig_hit;
  logic              wr_en;
  logic              rd_en;
  logic              xfer;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  // ext_trig feeds the lost-trigger flag; trig_hit is what actually starts a capture.
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
  assign ext_trig = TRIG & ~TRIG_SRC;
  assign trig_hit = TRIG_SRC ? (IN_WE && (IN_DATA >= THRESH)) : TRIG;
`else
  assign ext_trig = TRIG;
  assign trig_hit = TRIG;
`endif

  assign wr_en = IN_WE && ((state_q == FILL) || (state_q == ARMED) || (state_q == POST));
  assign xfer  = rd_valid_q && RD_READY;
  assign rd_en = (state_q == READOUT);
  // Look one address ahead on a transfer so the next word is ready the following cycle.
  assign rd_addr = xfer ? ptr_add(rd_ptr_q, ADDR_W'(1)) : rd_ptr_q;

  circ_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (FASTCLK),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(IN_DATA),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    trig_lost_d = trig_lost_q;
    rd_valid_d  = rd_valid_q;

    if (wr_en) begin
      wr_ptr_d = ptr_add(wr_ptr_q, ADDR_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (ARM) begin
          state_d     = FILL;
          pre_cnt_d   = '0;
          trig_lost_d = 1'b0;
        end
      end

      FILL: begin
        if (ext_trig) begin
          trig_lost_d = 1'b1;
        end
        if (IN_WE) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_d == PRE_C) begin
            state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (trig_hit) begin
          state_d     = POST;
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = IN_WE ? (ADDR_W + 1)'(1) : '0;
          if (IN_WE && (post_cnt_d == POST_C)) begin
            state_d  = READOUT;
            rd_ptr_d = wr_ptr_d;
            rd_cnt_d = '0;
          end
        end
      end

      POST: begin
        if (IN_WE) begin
          post_cnt_d = post_cnt_q + 1'b1;
          // The write pointer now sits on the oldest sample of the frozen window.
          if (post_cnt_d == POST_C) begin
            state_d  = READOUT;
            rd_ptr_d = wr_ptr_d;
            rd_cnt_d = '0;
          end
        end
      end

      READOUT: begin
        rd_valid_d = 1'b1;
        if (xfer) begin
          rd_ptr_d = ptr_add(rd_ptr_q, ADDR_W'(1));
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_C) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FASTCLK) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      trig_lost_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      trig_lost_q <= trig_lost_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_valid_q ? ram_rdata : '0;
  assign RD_LAST   = rd_valid_q && (rd_cnt_q == LAST_C);
  assign TRIG_ADDR = trig_addr_q;
  assign BUSY      = (state_q != IDLE);
  assign TRIG_LOST = trig_lost_q;

endmodule

// File: tb/tb_adc_circ_buffer.sv
// Bench for adc_circ_buffer: capture scenarios from a vector table, scoreboard of written samples.
// Self-trigger sequence is compiled in when ADC_CIRC_BUFFER_SELF_TRIG_EN is defined.
module tb_adc_circ_buffer;

  logic        FASTCLK;
  logic        RESET_n;
  logic [11:0] IN_DATA;
  logic        IN_WE;
  logic        ARM;
  logic        TRIG;
  logic        RD_READY;
  logic [11:0] RD_DATA;
  logic        RD_VALID;
  logic        RD_LAST;
  logic [7:0]  TRIG_ADDR;
  logic        BUSY;
  logic        TRIG_LOST;
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
  logic        trigSrc;
`endif

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  typedef struct {
    bit doReset;
    int nPre;
    int base;
    int mode;
    bit early;
    int expTa;
    int expFirst;
    bit expLost;
  } vec_t;

  vec_t vecs[7];

  adc_circ_buffer dut (
    .FASTCLK  (FASTCLK),
    .RESET_n  (RESET_n),
    .IN_DATA  (IN_DATA),
    .IN_WE    (IN_WE),
    .ARM      (ARM),
    .TRIG     (TRIG),
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
    .TRIG_SRC (trigSrc),
`endif
    .RD_READY (RD_READY),
    .RD_DATA  (RD_DATA),
    .RD_VALID (RD_VALID),
    .RD_LAST  (RD_LAST),
    .TRIG_ADDR(TRIG_ADDR),
    .BUSY     (BUSY),
    .TRIG_LOST(TRIG_LOST)
  );

  initial FASTCLK = 1'b0;
  always #5 FASTCLK = ~FASTCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge FASTCLK);
    #1;
  endtask

  task automatic doReset();
    RESET_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_WE   = ~IN_WE;
      IN_DATA = 12'hFFF;
      tick();
    end
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_valid", RD_VALID, 0);
    checkOutput("reset_trig_addr", TRIG_ADDR, 0);
    checkOutput("reset_trig_lost", TRIG_LOST, 0);
    checkOutput("reset_last", RD_LAST, 0);
    IN_WE   = 1'b0;
    RESET_n = 1'b1;
  endtask

  task automatic writeSample(input logic [11:0] v, input logic t);
    IN_WE   = 1'b1;
    IN_DATA = v;
    TRIG    = t;
    sb.push_back(v);
    if (sb.size() > 256) void'(sb.pop_front());
    tick();
    TRIG = 1'b0;
  endtask

  // mode 0: always ready, 1: random, 2: random plus a 20-cycle stall, 3: reset at word 50
  task automatic doReadout(input int mode, input int expFirst);
    int n = 0;
    int cyc = 0;
    int stall = 0;
    bit stallDone = 0;
    bit pv = 0;
    bit pr = 0;
    bit r;
    logic [11:0] held = '0;
    logic [11:0] exp;
    while (n < 256 && cyc < 5000) begin
      if (pv && !pr) begin
        checkOutput("stall_valid", RD_VALID, 1);
        checkOutput("stall_data", RD_DATA, held);
      end
      if (mode == 3 && n == 50 && RD_VALID) begin
        RESET_n  = 1'b0;
        RD_READY = 1'b0;
        tick();
        checkOutput("midreset_valid", RD_VALID, 0);
        checkOutput("midreset_busy", BUSY, 0);
        RESET_n = 1'b1;
        sb.delete();
        return;
      end
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 2 && n == 100 && !stallDone) begin
        stall     = 20;
        stallDone = 1;
      end
      if (stall > 0) begin
        r = 1'b0;
        stall--;
      end
      RD_READY = r;
      if (RD_VALID && r) begin
        exp = sb.pop_front();
        if (n == 0) checkOutput("first_word", RD_DATA, expFirst);
        checkOutput("rd_data", RD_DATA, exp);
        checkOutput("rd_last", RD_LAST, (n == 255));
        n++;
      end
      pv   = RD_VALID;
      pr   = r;
      held = RD_DATA;
      tick();
      cyc++;
    end
    RD_READY = 1'b0;
    checkOutput("transfer_count", n, 256);
    checkOutput("end_valid", RD_VALID, 0);
    checkOutput("end_busy", BUSY, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doReset) doReset();
    sb.delete();
    // Writes while idle must be ignored.
    IN_WE   = 1'b1;
    IN_DATA = 12'hABC;
    repeat (3) tick();
    IN_WE = 1'b0;
    ARM   = 1'b1;
    tick();
    ARM = 1'b0;
    checkOutput("arm_busy", BUSY, 1);
    checkOutput("arm_clears_lost", TRIG_LOST, 0);
    for (int i = 0; i < v.nPre; i++) writeSample(12'(v.base + i), v.early && (i == 10));
    writeSample(12'(v.base + v.nPre), 1'b1);
    for (int i = 0; i < 191; i++) writeSample(12'(v.base + v.nPre + 1 + i), 1'b0);
    // Writes during readout must not reach the RAM.
    IN_WE   = 1'b1;
    IN_DATA = 12'h5A5;
    checkOutput("trig_addr", TRIG_ADDR, v.expTa);
    checkOutput("trig_lost", TRIG_LOST, v.expLost);
    doReadout(v.mode, v.expFirst);
    IN_WE = 1'b0;
  endtask

  initial begin
    RESET_n  = 1'b0;
    IN_DATA  = '0;
    IN_WE    = 1'b0;
    ARM      = 1'b0;
    TRIG     = 1'b0;
    RD_READY = 1'b0;
`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
    trigSrc  = 1'b0;
`endif

    //            reset nPre  base  mode early expTa expFirst lost
    vecs[0] = '{1'b1, 100,  0,    0,   1'b0, 100,  36,      1'b0};
    vecs[1] = '{1'b1, 150,  200,  0,   1'b1, 150,  286,     1'b1};
    vecs[2] = '{1'b0, 70,   40,   1,   1'b0, 156,  46,      1'b0};
    vecs[3] = '{1'b1, 1000, 0,    0,   1'b0, 232,  936,     1'b0};
    vecs[4] = '{1'b1, 300,  3000, 2,   1'b0, 44,   3236,    1'b0};
    vecs[5] = '{1'b1, 64,   7,    3,   1'b0, 64,   7,       1'b0};
    vecs[6] = '{1'b0, 80,   100,  0,   1'b0, 80,   116,     1'b0};

    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k]);
    end

`ifdef ADC_CIRC_BUFFER_SELF_TRIG_EN
    doReset();
    sb.delete();
    trigSrc = 1'b1;
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    for (int i = 0; i < 64; i++) writeSample(12'(100 + i), 1'b0);
    writeSample(12'd2047, 1'b0);
    writeSample(12'd5, 1'b1);
    writeSample(12'd2048, 1'b0);
    checkOutput("self_busy_post", BUSY, 1);
    for (int i = 0; i < 191; i++) writeSample(12'(10 + i), 1'b0);
    IN_WE = 1'b0;
    checkOutput("self_trig_addr", TRIG_ADDR, 66);
    doReadout(0, 102);
    trigSrc = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
